// File: rtl/systolic_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the systolic node.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_MAC     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_A_LEFT  = 4'd3;
    localparam logic [3:0] OP_A_RIGHT = 4'd4;
    localparam logic [3:0] OP_B_UP    = 4'd5;
    localparam logic [3:0] OP_B_DOWN  = 4'd6;
    localparam logic [3:0] OP_A_LOAD  = 4'd7;
    localparam logic [3:0] OP_B_LOAD  = 4'd8;
    localparam logic [3:0] OP_S_LOAD  = 4'd9;
    localparam logic [3:0] OP_CLEAR   = 4'd10;

    // Opcodes that go through the multiplier pipeline instead of completing at once.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MAC) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/systolic_node_pe_multiplier.sv
// Pipelined PRECISION x PRECISION multiplier with a valid bit travelling alongside the product.
// Latency: MUL_LATENCY cycles from in_vld to out_vld; one operation may enter every cycle.
// Backpressure: none; the consumer must take prod_dat while out_vld is high. Reset flushes the pipe.
// Ports: clk, reset (sync, active-high), in_vld/a_dat/b_dat in, out_vld/prod_dat (2*PRECISION) out.
module pe_multiplier #(
    parameter int PRECISION   = 8,
    parameter int MUL_LATENCY = 2,
    parameter int SIGNED      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld,
    input  logic [PRECISION-1:0]     a_dat,
    input  logic [PRECISION-1:0]     b_dat,
    output logic                     out_vld,
    output logic [2*PRECISION-1:0]   prod_dat
);

    logic [2*PRECISION-1:0] a_ext;
    logic [2*PRECISION-1:0] b_ext;
    logic [2*PRECISION-1:0] prod_d [MUL_LATENCY];
    logic [2*PRECISION-1:0] prod_q [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] vld_d;
    logic [MUL_LATENCY-1:0] vld_q;

    // The low 2*PRECISION bits of a product of operands extended to 2*PRECISION
    // are the correct signed or unsigned result, so one multiplier serves both modes.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{PRECISION{a_dat[PRECISION-1]}}, a_dat};
            b_ext = {{PRECISION{b_dat[PRECISION-1]}}, b_dat};
        end else begin
            a_ext = {{PRECISION{1'b0}}, a_dat};
            b_ext = {{PRECISION{1'b0}}, b_dat};
        end
    end

    always_comb begin
        for (int i = 0; i < MUL_LATENCY; i++) begin
            if (i == 0) begin
                prod_d[i] = a_ext * b_ext;
                vld_d[i]  = in_vld;
            end else begin
                prod_d[i] = prod_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= prod_d[i];
            end
            vld_q <= vld_d;
        end
    end

    assign out_vld  = vld_q[MUL_LATENCY-1];
    assign prod_dat = prod_q[MUL_LATENCY-1];

endmodule

// File: rtl/systolic_node.sv
// Systolic array processing element: A/B operand registers, neighbour shifts and a MAC accumulator.
// Latency: register ops complete 1 cycle after accept; MAC/MUL complete MUL_LATENCY+1 cycles after accept.
// Backpressure: cmd_ready only in IDLE; done is held until ack, and no command is taken meanwhile.
// Ports: CLK, reset (sync, active-high); cmd_valid/cmd_ready/cmd/done/ack/cmd_err handshake;
//        isl/isr/isu/isd neighbour inputs, a/b/s_overwrite direct loads; osa/osb/A/B/s_out outputs.
module systolic_node #(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32,
    parameter int MUL_LATENCY      = 2,
    parameter int SIGNED           = 0,
    parameter int SATURATE         = 0
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd,
    output logic                        done,
    input  logic                        ack,
    output logic                        cmd_err,
    input  logic [PRECISION-1:0]        isl,
    input  logic [PRECISION-1:0]        isr,
    input  logic [PRECISION-1:0]        isu,
    input  logic [PRECISION-1:0]        isd,
    input  logic [PRECISION-1:0]        a_overwrite,
    input  logic [PRECISION-1:0]        b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0] s_overwrite,
    output logic [PRECISION-1:0]        osa,
    output logic [PRECISION-1:0]        osb,
    output logic [PRECISION-1:0]        A,
    output logic [PRECISION-1:0]        B,
    output logic [OUTPUT_PRECISION-1:0] s_out
);

    import systolic_pkg::*;

    if (OUTPUT_PRECISION < 2 * PRECISION) begin : g_bad_output_precision
        $error("systolic_node: OUTPUT_PRECISION must be >= 2*PRECISION");
    end
    if (MUL_LATENCY < 1 || MUL_LATENCY > 8) begin : g_bad_mul_latency
        $error("systolic_node: MUL_LATENCY must be in 1..8");
    end

    state_e                      state_q, state_d;
    logic [PRECISION-1:0]        a_q, a_d;
    logic [PRECISION-1:0]        b_q, b_d;
    logic [OUTPUT_PRECISION-1:0] s_q, s_d;
    logic                        err_q, err_d;
    logic                        mac_q, mac_d;

    logic                        mul_start;
    logic                        mul_vld;
    logic [2*PRECISION-1:0]      prod;
    logic [OUTPUT_PRECISION-1:0] prod_ext;
    logic [OUTPUT_PRECISION:0]   usum;
    logic [OUTPUT_PRECISION-1:0] wsum;
    logic [OUTPUT_PRECISION-1:0] smin;
    logic                        sovf;
    logic [OUTPUT_PRECISION-1:0] mac_res;

    // Operands are sampled from the A/B registers at the accept edge; the
    // registers cannot change while BUSY since commands are only taken in IDLE.
    assign mul_start = cmd_valid && (state_q == ST_IDLE) && is_mul_op(cmd);

    pe_multiplier #(
        .PRECISION   (PRECISION),
        .MUL_LATENCY (MUL_LATENCY),
        .SIGNED      (SIGNED)
    ) u_mul (
        .clk      (CLK),
        .reset    (reset),
        .in_vld   (mul_start),
        .a_dat    (a_q),
        .b_dat    (b_q),
        .out_vld  (mul_vld),
        .prod_dat (prod)
    );

    always_comb begin
        if (SIGNED != 0) begin
            prod_ext = OUTPUT_PRECISION'($signed(prod));
        end else begin
            prod_ext = OUTPUT_PRECISION'(prod);
        end
    end

    // Accumulate with one extra bit for unsigned carry-out; signed overflow is
    // the classic "same-sign operands, different-sign result" test.
    always_comb begin
        usum = {1'b0, s_q} + {1'b0, prod_ext};
        wsum = usum[OUTPUT_PRECISION-1:0];
        smin = '0;
        smin[OUTPUT_PRECISION-1] = 1'b1;
        sovf = (s_q[OUTPUT_PRECISION-1] == prod_ext[OUTPUT_PRECISION-1]) &&
               (wsum[OUTPUT_PRECISION-1] != s_q[OUTPUT_PRECISION-1]);
        mac_res = wsum;
        if (SATURATE != 0) begin
            if (SIGNED != 0) begin
                if (sovf) begin
                    mac_res = s_q[OUTPUT_PRECISION-1] ? smin : ~smin;
                end
            end else if (usum[OUTPUT_PRECISION]) begin
                mac_res = '1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        err_d   = err_q;
        mac_d   = mac_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_DONE;
                    case (cmd)
                        OP_NOP:     ;
                        OP_MAC,
                        OP_MUL: begin
                            state_d = ST_BUSY;
                            mac_d   = (cmd == OP_MAC);
                        end
                        OP_A_LEFT:  a_d = isl;
                        OP_A_RIGHT: a_d = isr;
                        OP_B_UP:    b_d = isu;
                        OP_B_DOWN:  b_d = isd;
                        OP_A_LOAD:  a_d = a_overwrite;
                        OP_B_LOAD:  b_d = b_overwrite;
                        OP_S_LOAD:  s_d = s_overwrite;
                        OP_CLEAR: begin
                            a_d = '0;
                            b_d = '0;
                            s_d = '0;
                        end
                        default:    err_d = 1'b1;
                    endcase
                end
            end
            ST_BUSY: begin
                if (mul_vld) begin
                    s_d     = mac_q ? mac_res : prod_ext;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
            mac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            err_q   <= err_d;
            mac_q   <= mac_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign cmd_err   = err_q;
    assign A         = a_q;
    assign B         = b_q;
    assign osa       = a_q;
    assign osb       = b_q;
    assign s_out     = s_q;

endmodule

// File: tb/tb_systolic_node.sv
// Bench for systolic_node: four lockstep nodes covering SIGNED x SATURATE plus a 2x2 shift array.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_node;

    localparam int P  = 8;
    localparam int OP = 32;
    localparam int L  = 2;
    localparam int LA = 3;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- lockstep configuration nodes (index = SIGNED*2 + SATURATE)
    logic        cmd_valid = 1'b0;
    logic        ack       = 1'b0;
    logic [3:0]  cmd       = '0;
    logic [7:0]  isl = '0, isr = '0, isu = '0, isd = '0, a_ow = '0, b_ow = '0;
    logic [31:0] s_ow = '0;

    logic [3:0]        c_rdy, c_done, c_err;
    logic [3:0][7:0]   c_a, c_b, c_osa, c_osb;
    logic [3:0][31:0]  c_s;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        systolic_node #(
            .PRECISION(P), .OUTPUT_PRECISION(OP), .MUL_LATENCY(L),
            .SIGNED(g / 2), .SATURATE(g % 2)
        ) u_dut (
            .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(c_rdy[g]),
            .cmd(cmd), .done(c_done[g]), .ack(ack), .cmd_err(c_err[g]),
            .isl(isl), .isr(isr), .isu(isu), .isd(isd),
            .a_overwrite(a_ow), .b_overwrite(b_ow), .s_overwrite(s_ow),
            .osa(c_osa[g]), .osb(c_osb[g]), .A(c_a[g]), .B(c_b[g]), .s_out(c_s[g])
        );
    end

    // ---------------- 2x2 array, node index = row*2 + col
    logic             arr_vld = 1'b0;
    logic             arr_ack = 1'b0;
    logic [3:0]       arr_cmd = '0;
    logic [3:0][7:0]  arr_aow = '0, arr_bow = '0;
    logic [3:0]       arr_rdy, arr_done, arr_err;
    logic [3:0][7:0]  arr_a, arr_b, arr_osa, arr_osb, arr_isl, arr_isr, arr_isu, arr_isd;
    logic [3:0][31:0] arr_s;

    assign arr_isl[0] = 8'hE0;       assign arr_isl[1] = arr_osa[0];
    assign arr_isl[2] = 8'hE2;       assign arr_isl[3] = arr_osa[2];
    assign arr_isr[0] = arr_osa[1];  assign arr_isr[1] = 8'hE1;
    assign arr_isr[2] = arr_osa[3];  assign arr_isr[3] = 8'hE3;
    assign arr_isu[0] = 8'hD0;       assign arr_isu[1] = 8'hD1;
    assign arr_isu[2] = arr_osb[0];  assign arr_isu[3] = arr_osb[1];
    assign arr_isd[0] = arr_osb[2];  assign arr_isd[1] = arr_osb[3];
    assign arr_isd[2] = 8'hD2;       assign arr_isd[3] = 8'hD3;

    for (genvar g = 0; g < 4; g++) begin : g_arr
        systolic_node #(.MUL_LATENCY(LA)) u_node (
            .CLK(CLK), .reset(reset), .cmd_valid(arr_vld), .cmd_ready(arr_rdy[g]),
            .cmd(arr_cmd), .done(arr_done[g]), .ack(arr_ack), .cmd_err(arr_err[g]),
            .isl(arr_isl[g]), .isr(arr_isr[g]), .isu(arr_isu[g]), .isd(arr_isd[g]),
            .a_overwrite(arr_aow[g]), .b_overwrite(arr_bow[g]), .s_overwrite(32'h0),
            .osa(arr_osa[g]), .osb(arr_osb[g]), .A(arr_a[g]), .B(arr_b[g]), .s_out(arr_s[g])
        );
    end

    // ---------------- comparison helper
    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
        end
    endtask

    // ---------------- behavioural reference model (plain integer arithmetic)
    int     m_a [4];
    int     m_b [4];
    longint m_s [4];
    bit     m_err [4];

    function automatic longint sx8(input int v, input int sg);
        return (sg != 0 && v >= 128) ? longint'(v) - 256 : longint'(v);
    endfunction

    function automatic longint sx32(input longint v, input int sg);
        return (sg != 0 && v >= 64'sh8000_0000) ? v - 64'sh1_0000_0000 : v;
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < 4; g++) begin
            m_a[g] = 0; m_b[g] = 0; m_s[g] = 0; m_err[g] = 1'b0;
        end
    endfunction

    function automatic void model_exec(input logic [3:0] op);
        longint p, sum;
        for (int g = 0; g < 4; g++) begin
            int sg  = g / 2;
            int sat = g % 2;
            case (op)
                4'd1, 4'd2: begin
                    p = sx8(m_a[g], sg) * sx8(m_b[g], sg);
                    if (op == 4'd2) begin
                        sum = p;
                    end else begin
                        sum = sx32(m_s[g], sg) + p;
                        if (sat != 0) begin
                            if (sg != 0) begin
                                if (sum > 64'sh7FFF_FFFF) sum = 64'sh7FFF_FFFF;
                                else if (sum < -64'sh8000_0000) sum = -64'sh8000_0000;
                            end else if (sum > 64'shFFFF_FFFF) begin
                                sum = 64'shFFFF_FFFF;
                            end
                        end
                    end
                    m_s[g] = sum & 64'hFFFF_FFFF;
                end
                4'd0:  ;
                4'd3:  m_a[g] = int'(isl);
                4'd4:  m_a[g] = int'(isr);
                4'd5:  m_b[g] = int'(isu);
                4'd6:  m_b[g] = int'(isd);
                4'd7:  m_a[g] = int'(a_ow);
                4'd8:  m_b[g] = int'(b_ow);
                4'd9:  m_s[g] = longint'(s_ow);
                4'd10: begin m_a[g] = 0; m_b[g] = 0; m_s[g] = 0; end
                default: m_err[g] = 1'b1;
            endcase
        end
    endfunction

    // ---------------- scoreboard
    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][31:0] s;
        logic [3:0]       err;
        logic [31:0]      acc;
        logic [31:0]      lat;
    } exp_t;

    exp_t exp_q [$];

    function automatic void push_expect(input logic [3:0] op);
        exp_t e;
        model_exec(op);
        e.acc = cyc;
        e.lat = (op == 4'd1 || op == 4'd2) ? L + 1 : 1;
        for (int g = 0; g < 4; g++) begin
            e.a[g]   = 8'(m_a[g]);
            e.b[g]   = 8'(m_b[g]);
            e.s[g]   = 32'(m_s[g]);
            e.err[g] = m_err[g];
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: every rising done pops one expectation and compares all four nodes.
    bit done_prev = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (c_done[0] && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, want no completion pending");
            end else begin
                e = exp_q.pop_front();
                chk("latency", cyc - int'(e.acc), e.lat);
                for (int g = 0; g < 4; g++) begin
                    chk($sformatf("cfg%0d_done", g), c_done[g], 1);
                    chk($sformatf("cfg%0d_A", g),    c_a[g],    e.a[g]);
                    chk($sformatf("cfg%0d_B", g),    c_b[g],    e.b[g]);
                    chk($sformatf("cfg%0d_osa", g),  c_osa[g],  e.a[g]);
                    chk($sformatf("cfg%0d_osb", g),  c_osb[g],  e.b[g]);
                    chk($sformatf("cfg%0d_s", g),    c_s[g],    e.s[g]);
                    chk($sformatf("cfg%0d_err", g),  c_err[g],  e.err[g]);
                end
            end
        end
        done_prev = c_done[0];
    end

    // ---------------- drivers (called at a negedge, return at a negedge)
    task automatic randomize_ops();
        isl = 8'($urandom); isr = 8'($urandom); isu = 8'($urandom); isd = 8'($urandom);
        a_ow = 8'($urandom); b_ow = 8'($urandom); s_ow = $urandom;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input logic [31:0] sv, output int acc);
        int t = 0;
        acc = -1;
        while (!c_rdy[0] && t < 50) begin @(negedge CLK); t++; end
        if (!c_rdy[0]) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: got cmd_ready=0, want 1 within 50 cycles");
            return;
        end
        randomize_ops();
        a_ow = av; b_ow = bv; s_ow = sv; cmd = op; cmd_valid = 1'b1;
        push_expect(op);
        acc = cyc;
        @(negedge CLK);
        cmd_valid = 1'b0;
        randomize_ops();
        t = 0;
        while (!c_done[0] && t < 20) begin @(negedge CLK); randomize_ops(); t++; end
        if (!c_done[0]) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got done=0, want 1 within 20 cycles");
        end
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_cfg%0d_A", tag, g),    c_a[g],    0);
            chk($sformatf("%s_cfg%0d_B", tag, g),    c_b[g],    0);
            chk($sformatf("%s_cfg%0d_s", tag, g),    c_s[g],    0);
            chk($sformatf("%s_cfg%0d_err", tag, g),  c_err[g],  0);
            chk($sformatf("%s_cfg%0d_rdy", tag, g),  c_rdy[g],  1);
            chk($sformatf("%s_cfg%0d_done", tag, g), c_done[g], 0);
        end
    endtask

    // Reset with a load command and ack offered at the same time; reset must win.
    task automatic do_reset();
        reset = 1'b1; cmd = 4'd7; a_ow = 8'hAA; cmd_valid = 1'b1; ack = 1'b1;
        @(negedge CLK);
        reset = 1'b0; cmd_valid = 1'b0; ack = 1'b0;
        model_reset();
        reset_checks("reset");
    endtask

    task automatic run_arr(input logic [3:0] op, output int lat);
        int t = 0;
        int acc;
        arr_cmd = op; arr_vld = 1'b1; acc = cyc;
        @(negedge CLK);
        arr_vld = 1'b0;
        while (!arr_done[0] && t < 20) begin @(negedge CLK); t++; end
        lat = cyc - acc;
        if (!arr_done[0]) begin
            n_cmp++; n_fail++;
            $display("FAIL arr_done_timeout: got done=0, want 1 within 20 cycles");
        end
        arr_ack = 1'b1;
        @(negedge CLK);
        arr_ack = 1'b0;
    endtask

    // ---------------- main sequence
    initial begin
        int acc, rc, lat;
        int ea [4];
        int eb [4];
        int nx [4];
        logic [3:0]  op;
        logic [31:0] sv;

        repeat (2) @(negedge CLK);
        do_reset();

        // Signed MAC: 10 + 3 * (-2) = 4
        issue(4'd7, 8'd3, 8'd0, 32'd0, acc);
        issue(4'd8, 8'd0, 8'hFE, 32'd0, acc);
        issue(4'd9, 8'd0, 8'd0, 32'd10, acc);
        issue(4'd1, 8'd0, 8'd0, 32'd0, acc);
        chk("signed_mac_s", c_s[2], 4);

        // Unsigned MAC near the top: saturating vs wrapping
        issue(4'd9, 8'd0, 8'd0, 32'hFFFF_FFF0, acc);
        issue(4'd7, 8'd255, 8'd0, 32'd0, acc);
        issue(4'd8, 8'd0, 8'd255, 32'd0, acc);
        issue(4'd1, 8'd0, 8'd0, 32'd0, acc);
        chk("unsigned_sat_s", c_s[1], 32'hFFFF_FFFF);
        chk("unsigned_wrap_s", c_s[0], 32'h0000_FDF1);

        // Illegal opcode: no register change, sticky error flag
        issue(4'd13, 8'd0, 8'd0, 32'd0, acc);
        chk("illegal_err", c_err[0], 1);
        issue(4'd2, 8'd0, 8'd0, 32'd0, acc);
        chk("illegal_err_sticky", c_err[3], 1);

        // cmd_valid held high, ack withheld for 5 cycles
        randomize_ops();
        cmd = 4'd9; s_ow = 32'h1234_5678; cmd_valid = 1'b1;
        push_expect(4'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            s_ow = $urandom;
            chk("held_valid_rdy_low", c_rdy[0], 0);
        end
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0; cmd_valid = 1'b0;
        chk("after_ack_rdy", c_rdy[0], 1);
        chk("after_ack_done", c_done[0], 0);
        @(negedge CLK);
        chk("single_exec_done", c_done[0], 0);
        chk("single_exec_s", c_s[0], 32'h1234_5678);

        // Reset in the second BUSY cycle of a MAC aborts it
        issue(4'd7, 8'd9, 8'd0, 32'd0, acc);
        cmd = 4'd1; cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("abort_busy1_done", c_done[0], 0);
        @(negedge CLK);
        chk("abort_busy2_done", c_done[0], 0);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        model_reset();
        rc = cyc;
        reset_checks("abort");
        issue(4'd7, 8'h5A, 8'd0, 32'd0, acc);
        chk("abort_next_accept_cycle", acc, rc);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("abort_no_late_done", c_done[0], 0);
        end

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            if (i % 50 == 49) do_reset();
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'd1;
            case ($urandom_range(0, 3))
                0:       sv = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
                1:       sv = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                2:       sv = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: sv = $urandom;
            endcase
            issue(op, 8'($urandom), 8'($urandom), sv, acc);
        end

        // 2x2 array: one-hop shifts of A (left) and B (up)
        for (int g = 0; g < 4; g++) begin
            ea[g] = g + 1;
            eb[g] = 10 * (g + 1);
            arr_aow[g] = 8'(ea[g]);
            arr_bow[g] = 8'(eb[g]);
        end
        run_arr(4'd7, lat);
        run_arr(4'd8, lat);
        for (int pass = 0; pass < 2; pass++) begin
            for (int g = 0; g < 4; g++) nx[g] = (g % 2 == 0) ? 8'hE0 + g : ea[g-1];
            run_arr(4'd3, lat);
            for (int g = 0; g < 4; g++) begin
                ea[g] = nx[g];
                chk($sformatf("arr_shift%0d_A%0d", pass, g), arr_a[g], ea[g]);
                chk($sformatf("arr_shift%0d_osa%0d", pass, g), arr_osa[g], ea[g]);
            end
        end
        for (int g = 0; g < 4; g++) nx[g] = (g < 2) ? 8'hD0 + g : eb[g-2];
        run_arr(4'd5, lat);
        for (int g = 0; g < 4; g++) begin
            eb[g] = nx[g];
            chk($sformatf("arr_shift_B%0d", g), arr_b[g], eb[g]);
        end
        run_arr(4'd2, lat);
        chk("arr_mul_latency", lat, LA + 1);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("arr_mul_s%0d", g), arr_s[g], ea[g] * eb[g]);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
